// File: rtl/iobuf_pkg.sv
// Shared constants and helpers for the bidirectional pad bank.
package iobuf_pkg;

   localparam logic IOBUF_T_HIZ   = 1'b1;
   localparam logic IOBUF_T_DRIVE = 1'b0;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned FILTER_LEN_DEF  = 4;

   // Counter width for a filter of n cycles; a 1-cycle filter still needs one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/IOBUF.sv
// Behavioural stand-in for the vendor IOBUF primitive; keep it out of the
// synthesis file list so the real library cell is picked up there.
module IOBUF (
   output wire O,
   inout  wire IO,
   input  wire I,
   input  wire T
);

   assign IO = T ? 1'bz : I;
   assign O  = IO;

endmodule

// File: rtl/iobuf_chan.sv
// One pad channel: registered drive/3-state, input synchroniser, glitch
// filter and edge pulses.
module iobuf_chan
   import iobuf_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF,
   parameter bit          OD          = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic data_i,
   input  logic data_t_i,
   output logic data_o,
   output logic rise_o,
   output logic fall_o,
   inout  wire  io
);

   localparam int unsigned    CNT_W   = clog2_min1(FILTER_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   logic                   drv_q;
   logic                   t_q;
   logic                   t_eff_c;
   logic                   pad;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CNT_W-1:0]       cnt_q;

   // Open-drain channels release the pad instead of driving a 1.
   always_comb begin
      t_eff_c = IOBUF_T_DRIVE;
      if (data_t_i == IOBUF_T_HIZ || (OD && data_i))
         t_eff_c = IOBUF_T_HIZ;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drv_q <= 1'b0;
         t_q   <= IOBUF_T_HIZ;
      end else begin
         drv_q <= data_i;
         t_q   <= t_eff_c;
      end
   end

   IOBUF u_iobuf (
      .O  (pad),
      .IO (io),
      .I  (drv_q),
      .T  (t_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)
         sync_q <= '0;
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Accept a new level only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         data_o <= 1'b0;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         if (s == data_o) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            cnt_q  <= '0;
            data_o <= s;
            rise_o <= s;
            fall_o <= ~s;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/iobuf_bank.sv
// Bank of WIDTH independent bidirectional pad channels.
module iobuf_bank
   import iobuf_pkg::*;
#(
   parameter int unsigned     WIDTH       = 8,
   parameter int unsigned     SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned     FILTER_LEN  = FILTER_LEN_DEF,
   parameter logic [WIDTH-1:0] OD_MASK    = {WIDTH{1'b0}}
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [WIDTH-1:0] data_t_i,
   output logic [WIDTH-1:0] data_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   inout  wire  [WIDTH-1:0] io
);

   for (genvar n = 0; n < WIDTH; n++) begin : g_chan
      iobuf_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .OD          (OD_MASK[n])
      ) u_chan (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .data_i   (data_i[n]),
         .data_t_i (data_t_i[n]),
         .data_o   (data_o[n]),
         .rise_o   (rise_o[n]),
         .fall_o   (fall_o[n]),
         .io       (io[n])
      );
   end

endmodule

// File: tb/tb_iobuf_bank.sv
// Bench for iobuf_bank: directed scenarios plus random traffic against a
// cycle-level reference model; pads are pulled up and may be driven by the bench.
module tb_iobuf_bank;

   localparam int unsigned W   = 8;
   localparam int unsigned SS  = 2;
   localparam int unsigned FL  = 4;
   localparam logic [7:0]  ODM = 8'h01;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [7:0] data_i, data_t_i, data_o, rise_o, fall_o;
   logic [7:0] tb_oe, tb_val;
   tri1  [7:0] io;

   always #5 clk = ~clk;

   for (genvar g = 0; g < W; g++) begin : g_drv
      assign io[g] = tb_oe[g] ? tb_val[g] : 1'bz;
   end

   iobuf_bank #(
      .WIDTH       (W),
      .SYNC_STAGES (SS),
      .FILTER_LEN  (FL),
      .OD_MASK     (ODM)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .data_i   (data_i),
      .data_t_i (data_t_i),
      .data_o   (data_o),
      .rise_o   (rise_o),
      .fall_o   (fall_o),
      .io       (io)
   );

   // Reference model: pad history delayed SS edges, run length of disagreement.
   logic [7:0] m_drv, m_t, m_out, m_rise, m_fall;
   logic [7:0] hist[$];
   int         run_len[8];
   int         checks   = 0;
   int         failures = 0;

   function automatic logic [7:0] pad_now();
      return (~m_t & m_drv) | (m_t & tb_oe & tb_val) | (m_t & ~tb_oe);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [7:0] pad, s;
      pad = pad_now();
      if (rst_i) begin
         m_drv = 8'h00; m_t = 8'hFF;
         m_out = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
         foreach (run_len[n]) run_len[n] = 0;
         hist.delete();
         repeat (SS) hist.push_back(8'h00);
      end else begin
         s = hist.pop_front();
         hist.push_back(pad);
         m_rise = 8'h00; m_fall = 8'h00;
         for (int n = 0; n < 8; n++) begin
            if (s[n] == m_out[n]) begin
               run_len[n] = 0;
            end else begin
               run_len[n]++;
               if (run_len[n] == FL) begin
                  m_out[n]  = s[n];
                  m_rise[n] = s[n];
                  m_fall[n] = ~s[n];
                  run_len[n] = 0;
               end
            end
         end
         m_drv = data_i;
         m_t   = data_t_i | (ODM & data_i);
      end
   endtask

   // One clock: apply inputs at negedge, update model at posedge, compare just after.
   task automatic step(input logic r, input logic [7:0] d, input logic [7:0] t,
                       input logic [7:0] oe, input logic [7:0] v);
      @(negedge clk);
      rst_i    = r;
      data_i   = d;
      data_t_i = t;
      tb_oe    = oe & m_t & (r ? 8'hFF : (t | (ODM & d)));
      tb_val   = v;
      @(posedge clk);
      model_edge();
      #1;
      check("data_o", data_o, m_out);
      check("rise_o", rise_o, m_rise);
      check("fall_o", fall_o, m_fall);
      check("io", io, pad_now());
      check("excl", rise_o & fall_o, 8'h00);
   endtask

   task automatic run_until(input logic [7:0] d, input logic [7:0] t, input logic [7:0] oe,
                            input logic [7:0] v, input bit want_rise, input string tag,
                            input logic [7:0] exp);
      logic [7:0] seen;
      seen = 8'h00;
      for (int i = 0; i < 20 && seen == 8'h00; i++) begin
         step(1'b0, d, t, oe, v);
         seen = want_rise ? rise_o : fall_o;
      end
      check(tag, seen, exp);
   endtask

   initial begin
      logic [7:0] d, t, oe, v;
      logic       r;
      rst_i = 1'b1; data_i = 8'h00; data_t_i = 8'h00; tb_oe = 8'h00; tb_val = 8'h00;
      m_drv = 8'h00; m_t = 8'hFF; m_out = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
      repeat (SS) hist.push_back(8'h00);

      // Reset: drive requested but pads stay released (pull-up reads FF).
      repeat (3) begin
         step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
         check("rst_io_hiz", io, 8'hFF);
         check("rst_outs", {data_o, rise_o, fall_o}, 24'h0);
      end
      step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("rel_io", io, 8'h00);
      repeat (6) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Push-pull A5 with exact input latency.
      step(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00);
      check("pp_io", io, 8'hA5);
      repeat (5) begin
         step(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00);
         check("pp_early", data_o, 8'h00);
      end
      step(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00);
      check("pp_data", data_o, 8'hA5);
      check("pp_rise", rise_o, 8'hA5);
      step(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00);
      check("pp_rise_1cyc", rise_o, 8'h00);

      // Multi-channel simultaneous edges.
      run_until(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "mc_fall", 8'hA5);
      repeat (2) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      run_until(8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, "mc_rise", 8'hFF);

      // Open-drain channel 0: releases for 1, drives 0.
      step(1'b0, 8'hFF, 8'h00, 8'h00, 8'h00);
      check("od_hiz_reads1", io, 8'hFF);
      step(1'b0, 8'hFE, 8'h00, 8'h00, 8'h00);
      check("od_drive0", io, 8'hFE);
      run_until(8'hFE, 8'h00, 8'h00, 8'h00, 1'b0, "od_fall", 8'h01);

      // Glitch reject on pad 0 driven by the bench.
      repeat (8) step(1'b0, 8'hFE, 8'h01, 8'h01, 8'h00);
      repeat (3) begin
         step(1'b0, 8'hFE, 8'h01, 8'h01, 8'h01);
         check("glitch_hold", {data_o[0], rise_o[0]}, 2'b00);
      end
      repeat (10) begin
         step(1'b0, 8'hFE, 8'h01, 8'h01, 8'h00);
         check("glitch_hold", {data_o[0], rise_o[0]}, 2'b00);
      end
      repeat (4) step(1'b0, 8'hFE, 8'h01, 8'h01, 8'h01);
      run_until(8'hFE, 8'h01, 8'h01, 8'h00, 1'b1, "glitch4_rise", 8'h01);
      run_until(8'hFE, 8'h01, 8'h01, 8'h00, 1'b0, "glitch4_fall", 8'h01);

      // Reset while filters are counting.
      repeat (10) step(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00);
      check("rmf_pre", data_o, 8'hA5);
      repeat (5) step(1'b0, 8'h5A, 8'h00, 8'h00, 8'h00);
      step(1'b1, 8'h5A, 8'h00, 8'h00, 8'h00);
      check("rmf_outs", {data_o, rise_o, fall_o}, 24'h0);
      repeat (5) begin
         step(1'b0, 8'h5A, 8'h00, 8'h00, 8'h00);
         check("rmf_early", data_o, 8'h00);
      end
      step(1'b0, 8'h5A, 8'h00, 8'h00, 8'h00);
      check("rmf_data", data_o, 8'h5A);
      check("rmf_rise", rise_o, 8'h5A);

      // Random traffic with sparse toggles so both glitches and stable runs occur.
      d = 8'h5A; t = 8'h00; oe = 8'h00; v = 8'h00;
      repeat (600) begin
         d  ^= 8'($urandom & $urandom & $urandom);
         t  ^= 8'($urandom & $urandom & $urandom & $urandom);
         v  ^= 8'($urandom & $urandom);
         oe ^= 8'($urandom & $urandom & $urandom);
         r   = ($urandom_range(0, 99) == 0);
         step(r, d, t, oe, v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
